// File: rtl/z80_pkg.sv
// rtl/z80_pkg.sv - shared T-state/machine-cycle types and opcode constants for the Z80 bus front end
package z80_pkg;

   typedef enum logic [2:0] {T1, T2, TW, T3, T4, BUSREL} tstate_t;
   typedef enum logic [1:0] {M1, MR, MW, IOW} mcycle_t;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_LD_A_N  = 8'h3E;
   localparam logic [7:0] OP_LD_NN_A = 8'h32;
   localparam logic [7:0] OP_JP_NN   = 8'hC3;
   localparam logic [7:0] OP_OUT_N_A = 8'hD3;
   localparam logic [7:0] OP_HALT    = 8'h76;

endpackage

// File: rtl/z80_if.sv
// rtl/z80_if.sv - 40-pin Z80 bus signal bundle with CPU (master) and system (slave) views
interface z80_if;

   logic        nWAIT;
   logic        nINT;
   logic        nNMI;
   logic        nBUSRQ;
   logic        nM1;
   logic        nMREQ;
   logic        nIORQ;
   logic        nRD;
   logic        nWR;
   logic        nRFSH;
   logic        nHALT;
   logic        nBUSACK;
   wire  [15:0] A;
   wire  [7:0]  D;

   modport master (
      input  nWAIT, nINT, nNMI, nBUSRQ,
      output nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, nHALT, nBUSACK,
      inout  A, D
   );

   modport slave (
      output nWAIT, nINT, nNMI, nBUSRQ,
      input  nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, nHALT, nBUSACK,
      inout  A, D
   );

endinterface

// File: rtl/z80_bus_seq.sv
// rtl/z80_bus_seq.sv - T-state sequencer driving Z80 control pins per machine cycle
// Z80_REFRESH_EN selects the refresh phase (nMREQ/nRFSH low, refresh address) in M1 T3/T4.
module z80_bus_seq
   import z80_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  mcycle_t     i_mc,
   input  logic        i_nwait,
   input  logic        i_nbusrq,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_rfsh_addr,
   output logic        o_latch,
   output logic        o_mc_done,
   output logic        o_nm1,
   output logic        o_nmreq,
   output logic        o_niorq,
   output logic        o_nrd,
   output logic        o_nwr,
   output logic        o_nrfsh,
   output logic        o_nbusack,
   output logic [15:0] o_a,
   output logic        o_a_oe,
   output logic        o_d_oe
);

   tstate_t r_ts, w_ts_next;
   logic    r_busack_n, w_busack_n_next;
   logic    w_last;
   logic    w_unused_rfsh;

   assign w_unused_rfsh = ^i_rfsh_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts       <= T1;
         r_busack_n <= 1'b1;
      end else begin
         r_ts       <= w_ts_next;
         r_busack_n <= w_busack_n_next;
      end
   end

   always_comb begin
      w_ts_next       = r_ts;
      w_busack_n_next = r_busack_n;
      w_last          = (r_ts == T4) || (r_ts == T3 && i_mc != M1);
      case (r_ts)
         T1:      w_ts_next = T2;
         // I/O cycles always get one wait state before nWAIT is honoured
         T2:      w_ts_next = (i_mc == IOW || !i_nwait) ? TW : T3;
         TW:      w_ts_next = i_nwait ? T3 : TW;
         T3:      w_ts_next = (i_mc == M1) ? T4 : T1;
         T4:      w_ts_next = T1;
         BUSREL: begin
            if (!r_busack_n) begin
               if (i_nbusrq) w_busack_n_next = 1'b1;
            end else begin
               w_ts_next = T1;
            end
         end
         default: w_ts_next = T1;
      endcase
      if (w_last && !i_nbusrq) begin
         w_ts_next       = BUSREL;
         w_busack_n_next = 1'b0;
      end
      o_mc_done = w_last;
      o_latch   = (r_ts == T2 || r_ts == TW) && i_nwait && (i_mc == M1 || i_mc == MR);
   end

   always_comb begin
      o_nm1     = 1'b1;
      o_nmreq   = 1'b1;
      o_niorq   = 1'b1;
      o_nrd     = 1'b1;
      o_nwr     = 1'b1;
      o_nrfsh   = 1'b1;
      o_nbusack = 1'b1;
      o_a       = 16'h0000;
      o_a_oe    = 1'b1;
      o_d_oe    = 1'b0;
      if (rst_n) begin
         if (r_ts == BUSREL) begin
            if (!r_busack_n) begin
               o_nbusack = 1'b0;
               o_a_oe    = 1'b0;
            end
         end else begin
            o_a = i_addr;
            case (i_mc)
               M1: begin
                  if (r_ts == T3 || r_ts == T4) begin
`ifdef Z80_REFRESH_EN
                     o_nmreq = 1'b0;
                     o_nrfsh = 1'b0;
                     o_a     = i_rfsh_addr;
`endif
                  end else begin
                     o_nm1   = 1'b0;
                     o_nmreq = 1'b0;
                     o_nrd   = 1'b0;
                  end
               end
               MR: begin
                  if (r_ts != T3) begin
                     o_nmreq = 1'b0;
                     o_nrd   = 1'b0;
                  end
               end
               MW: begin
                  o_d_oe = 1'b1;
                  if (r_ts != T3) o_nmreq = 1'b0;
                  if (r_ts == T2 || r_ts == TW) o_nwr = 1'b0;
               end
               IOW: begin
                  o_d_oe = 1'b1;
                  if (r_ts == T2 || r_ts == TW) begin
                     o_niorq = 1'b0;
                     o_nwr   = 1'b0;
                  end
               end
               default: o_a = i_addr;
            endcase
         end
      end
   end

endmodule

// File: rtl/z80_top_direct.sv
// rtl/z80_top_direct.sv - Z80-compatible CPU top: registers, instruction decode, pin-level bus
// Z80_REFRESH_EN adds the 7-bit R register shown on A[6:0] during refresh.
module z80_top_direct
   import z80_pkg::*;
(
   input  logic  CLK,
   input  logic  nRESET,
   z80_if.master bus
);

   logic [15:0] r_pc, w_pc_next;
   logic [7:0]  r_acc;
   logic [7:0]  r_opcode;
   logic [7:0]  r_op_lo;
   logic [7:0]  r_op_hi;
   mcycle_t     r_mc, w_mc_next;
   logic        r_step, w_step_next;
   logic        r_halt, w_halt_next;
   logic [6:0]  w_r;
   logic [15:0] w_addr;
   logic [15:0] w_a;
   logic        w_a_oe;
   logic        w_d_oe;
   logic        w_latch;
   logic        w_mc_done;
   logic        w_unused;

`ifdef Z80_REFRESH_EN
   logic [6:0] r_r;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) r_r <= 7'd0;
      else if (w_mc_done && r_mc == M1) r_r <= r_r + 7'd1;
   end
   assign w_r = r_r;
`else
   assign w_r = 7'd0;
`endif

   assign w_unused = ^{bus.nINT, bus.nNMI};

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_pc     <= 16'h0000;
         r_acc    <= 8'hFF;
         r_opcode <= OP_NOP;
         r_op_lo  <= 8'h00;
         r_op_hi  <= 8'h00;
         r_mc     <= M1;
         r_step   <= 1'b0;
         r_halt   <= 1'b0;
      end else begin
         r_pc   <= w_pc_next;
         r_mc   <= w_mc_next;
         r_step <= w_step_next;
         r_halt <= w_halt_next;
         if (w_latch) begin
            // halted fetches still run on the bus but their data is thrown away
            if (r_mc == M1) begin
               if (!r_halt) r_opcode <= bus.D;
            end else if (!r_step) begin
               r_op_lo <= bus.D;
               if (r_opcode == OP_LD_A_N) r_acc <= bus.D;
            end else begin
               r_op_hi <= bus.D;
            end
         end
      end
   end

   always_comb begin
      w_pc_next   = r_pc;
      w_mc_next   = r_mc;
      w_step_next = r_step;
      w_halt_next = r_halt;
      if (w_mc_done) begin
         case (r_mc)
            M1: begin
               w_mc_next = M1;
               if (!r_halt) begin
                  w_pc_next = r_pc + 16'd1;
                  case (r_opcode)
                     OP_HALT: w_halt_next = 1'b1;
                     OP_LD_A_N, OP_LD_NN_A, OP_JP_NN, OP_OUT_N_A: begin
                        w_mc_next   = MR;
                        w_step_next = 1'b0;
                     end
                     default: w_mc_next = M1;
                  endcase
               end
            end
            MR: begin
               w_pc_next = r_pc + 16'd1;
               if (!r_step) begin
                  case (r_opcode)
                     OP_LD_A_N:  w_mc_next = M1;
                     OP_OUT_N_A: w_mc_next = IOW;
                     default: begin
                        w_mc_next   = MR;
                        w_step_next = 1'b1;
                     end
                  endcase
               end else if (r_opcode == OP_JP_NN) begin
                  w_pc_next = {r_op_hi, r_op_lo};
                  w_mc_next = M1;
               end else begin
                  w_mc_next = MW;
               end
            end
            default: w_mc_next = M1;
         endcase
      end
   end

   always_comb begin
      case (r_mc)
         MW:      w_addr = {r_op_hi, r_op_lo};
         IOW:     w_addr = {r_acc, r_op_lo};
         default: w_addr = r_pc;
      endcase
   end

   z80_bus_seq u_seq (
      .clk         (CLK),
      .rst_n       (nRESET),
      .i_mc        (r_mc),
      .i_nwait     (bus.nWAIT),
      .i_nbusrq    (bus.nBUSRQ),
      .i_addr      (w_addr),
      .i_rfsh_addr ({9'h000, w_r}),
      .o_latch     (w_latch),
      .o_mc_done   (w_mc_done),
      .o_nm1       (bus.nM1),
      .o_nmreq     (bus.nMREQ),
      .o_niorq     (bus.nIORQ),
      .o_nrd       (bus.nRD),
      .o_nwr       (bus.nWR),
      .o_nrfsh     (bus.nRFSH),
      .o_nbusack   (bus.nBUSACK),
      .o_a         (w_a),
      .o_a_oe      (w_a_oe),
      .o_d_oe      (w_d_oe)
   );

   assign bus.nHALT = ~r_halt;
   assign bus.A     = w_a_oe ? w_a : 16'hzzzz;
   assign bus.D     = w_d_oe ? r_acc : 8'hzz;

endmodule

// File: tb/tb_z80_top_direct.sv
// tb/tb_z80_top_direct.sv - directed pin-level bench for z80_top_direct (honours Z80_REFRESH_EN)
module tb_z80_top_direct;

`ifdef Z80_REFRESH_EN
   localparam bit RFSH = 1'b1;
`else
   localparam bit RFSH = 1'b0;
`endif

   // control pins packed as {nM1,nMREQ,nIORQ,nRD,nWR,nRFSH,nHALT,nBUSACK}
   localparam logic [15:0] CTL_IDLE  = 16'h00FF;
   localparam logic [15:0] CTL_FETCH = 16'h002F;
   localparam logic [15:0] CTL_RFSH  = RFSH ? 16'h00BB : 16'h00FF;
   localparam logic [15:0] CTL_MRD   = 16'h00AF;
   localparam logic [15:0] CTL_MW1   = 16'h00BF;
   localparam logic [15:0] CTL_MW2   = 16'h00B7;
   localparam logic [15:0] CTL_IOW   = 16'h00D7;
   localparam logic [15:0] CTL_BUSAK = 16'h00FE;

   logic        CLK;
   logic        nRESET;
   logic [7:0]  mem [0:65535];
   logic [15:0] ctl;
   logic [15:0] dbus;
   int          n_checks;
   int          n_fail;

   z80_if bus ();

   z80_top_direct dut (
      .CLK    (CLK),
      .nRESET (nRESET),
      .bus    (bus)
   );

   // memory answers reads; another master owns A/D while the CPU acknowledges a bus request
   assign bus.A = !bus.nBUSACK ? 16'hBEEF : 16'hzzzz;
   assign bus.D = (!bus.nMREQ && !bus.nRD) ? mem[bus.A] : (!bus.nBUSACK ? 8'h5A : 8'hzz);

   assign ctl  = {8'h00, bus.nM1, bus.nMREQ, bus.nIORQ, bus.nRD, bus.nWR, bus.nRFSH, bus.nHALT, bus.nBUSACK};
   assign dbus = {8'h00, bus.D};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rf_addr(input logic [15:0] pc, input logic [6:0] r);
      return RFSH ? {9'h000, r} : pc;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   // 5 ns reset pulse; returns 1 ns into the first T1 (sample index k = 0)
   task automatic do_reset(input string tag);
      @(posedge CLK);
      #2 nRESET = 1'b0;
      #2;
      check({tag, "_rst_ctl"}, ctl, CTL_IDLE);
      check({tag, "_rst_a"}, bus.A, 16'h0000);
      #3 nRESET = 1'b1;
      #1;
   endtask

   task automatic advance();
      @(posedge CLK);
      #3;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      nRESET      = 1'b0;
      bus.nWAIT   = 1'b1;
      bus.nINT    = 1'b1;
      bus.nNMI    = 1'b1;
      bus.nBUSRQ  = 1'b1;

      // NOP stream: M1 every 4 T-states, PC and R advance
      clear_mem();
      do_reset("nop");
      for (int k = 0; k < 12; k++) begin
         case (k)
            0:  begin check("nop_f0_ctl", ctl, CTL_FETCH); check("nop_f0_a", bus.A, 16'h0000); end
            2:  begin check("nop_r0_ctl", ctl, CTL_RFSH); check("nop_r0_a", bus.A, rf_addr(16'h0000, 7'd0)); end
            4:  begin check("nop_f1_ctl", ctl, CTL_FETCH); check("nop_f1_a", bus.A, 16'h0001); end
            6:  check("nop_r1_a", bus.A, rf_addr(16'h0001, 7'd1));
            8:  check("nop_f2_a", bus.A, 16'h0002);
            10: check("nop_r2_a", bus.A, rf_addr(16'h0002, 7'd2));
            default: ;
         endcase
         advance();
      end

      // LD A,55h ; LD (8000h),A
      clear_mem();
      mem[0] = 8'h3E; mem[1] = 8'h55; mem[2] = 8'h32; mem[3] = 8'h00; mem[4] = 8'h80;
      do_reset("ldw");
      for (int k = 0; k < 22; k++) begin
         case (k)
            4:  begin check("ldw_mr_ctl", ctl, CTL_MRD); check("ldw_mr_a", bus.A, 16'h0001); end
            14: check("ldw_hi_a", bus.A, 16'h0004);
            17: begin check("ldw_t1_ctl", ctl, CTL_MW1); check("ldw_t1_a", bus.A, 16'h8000); check("ldw_t1_d", dbus, 16'h0055); end
            18: begin check("ldw_t2_ctl", ctl, CTL_MW2); check("ldw_t2_d", dbus, 16'h0055); end
            19: begin check("ldw_t3_ctl", ctl, CTL_IDLE); check("ldw_t3_d", dbus, 16'h0055); end
            20: begin check("ldw_next_ctl", ctl, CTL_FETCH); check("ldw_next_a", bus.A, 16'h0005); end
            default: ;
         endcase
         advance();
      end

      // JP 1234h
      clear_mem();
      mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
      do_reset("jp");
      for (int k = 0; k < 16; k++) begin
         case (k)
            7:  check("jp_hi_a", bus.A, 16'h0002);
            10: begin check("jp_tgt_ctl", ctl, CTL_FETCH); check("jp_tgt_a", bus.A, 16'h1234); end
            14: check("jp_tgt1_a", bus.A, 16'h1235);
            default: ;
         endcase
         advance();
      end

      // LD A,ABh ; OUT (10h),A
      clear_mem();
      mem[0] = 8'h3E; mem[1] = 8'hAB; mem[2] = 8'hD3; mem[3] = 8'h10;
      do_reset("out");
      for (int k = 0; k < 20; k++) begin
         case (k)
            14: begin check("out_t1_ctl", ctl, CTL_IDLE); check("out_t1_a", bus.A, 16'hAB10); check("out_t1_d", dbus, 16'h00AB); end
            15: check("out_t2_ctl", ctl, CTL_IOW);
            16: begin check("out_tw_ctl", ctl, CTL_IOW); check("out_tw_d", dbus, 16'h00AB); end
            17: check("out_t3_ctl", ctl, CTL_IDLE);
            18: begin check("out_next_ctl", ctl, CTL_FETCH); check("out_next_a", bus.A, 16'h0004); end
            default: ;
         endcase
         advance();
      end

      // three wait states on the second fetch; opcode only becomes HALT during the last Tw
      clear_mem();
      do_reset("hlt");
      for (int k = 0; k < 20; k++) begin
         case (k)
            5:  begin check("hlt_t2_a", bus.A, 16'h0001); bus.nWAIT = 1'b0; end
            6:  begin check("hlt_tw1_ctl", ctl, CTL_FETCH); check("hlt_tw1_a", bus.A, 16'h0001); end
            8:  begin check("hlt_tw3_ctl", ctl, CTL_FETCH); mem[1] = 8'h76; bus.nWAIT = 1'b1; end
            9:  begin check("hlt_t3_ctl", ctl, CTL_RFSH); check("hlt_t3_a", bus.A, rf_addr(16'h0001, 7'd1)); end
            10: check("hlt_t4_ctl", ctl, CTL_RFSH);
            11: begin check("hlt_h1_ctl", ctl, CTL_FETCH & 16'hFFFD); check("hlt_h1_a", bus.A, 16'h0002); end
            15: begin check("hlt_h2_ctl", ctl, CTL_FETCH & 16'hFFFD); check("hlt_h2_a", bus.A, 16'h0002); end
            17: begin check("hlt_h2r_ctl", ctl, CTL_RFSH & 16'hFFFD); check("hlt_h2r_a", bus.A, rf_addr(16'h0002, 7'd3)); end
            19: check("hlt_h3_a", bus.A, 16'h0002);
            default: ;
         endcase
         advance();
      end

      // bus request raised mid operand read; LD A,77h ; OUT (05h),A resumes afterwards
      clear_mem();
      mem[0] = 8'h3E; mem[1] = 8'h77; mem[2] = 8'hD3; mem[3] = 8'h05;
      do_reset("brq");
      for (int k = 0; k < 20; k++) begin
         case (k)
            5:  bus.nBUSRQ = 1'b0;
            6:  begin check("brq_t3_ctl", ctl, CTL_IDLE); check("brq_t3_a", bus.A, 16'h0001); end
            7:  begin check("brq_ack_ctl", ctl, CTL_BUSAK); check("brq_ack_a", bus.A, 16'hBEEF); check("brq_ack_d", dbus, 16'h005A); end
            9:  begin check("brq_hold_ctl", ctl, CTL_BUSAK); bus.nBUSRQ = 1'b1; end
            10: check("brq_gap_ctl", ctl, CTL_IDLE);
            11: begin check("brq_res_ctl", ctl, CTL_FETCH); check("brq_res_a", bus.A, 16'h0002); end
            15: check("brq_mr_a", bus.A, 16'h0003);
            18: begin check("brq_iow_a", bus.A, 16'h7705); check("brq_iow_d", dbus, 16'h0077); end
            19: check("brq_iow_ctl", ctl, CTL_IOW);
            default: ;
         endcase
         advance();
      end

      do_reset("end");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
